// File: rtl/bram_arb_pkg.sv
// Shared constants and helpers for the BRAM port arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode strings
//   idx_width          : width of a requester index (min 1)
//   addr_width         : BRAM address width from depth (min 1)
//   onehot_to_idx      : one-hot vector to binary index
package bram_arb_pkg;

  localparam string ARB_RR    = "RR";
  localparam string ARB_FIXED = "FIXED";

  // Widest one-hot vector the index helper accepts.
  localparam int unsigned MAX_REQ = 32;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin / fixed-priority arbiter with its own rotation pointer.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   en_i          : grant enable (low forces no grant)
//   adv_i         : move the pointer past the current winner
//   gnt_o         : one-hot grant
//   gnt_idx_o     : binary index of the winner
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter string       ARB_MODE = ARB_RR,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  localparam bit IS_FIXED = (ARB_MODE == ARB_FIXED);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_sel;
  logic               w_found;
  int unsigned        w_base;
  int unsigned        w_k;

  // Scan from the pointer (or from 0 in fixed mode), wrapping modulo NUM_REQ.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_sel   = '0;
    w_base  = IS_FIXED ? 32'd0 : 32'(r_ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_k = w_base + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      w_sel = IDX_W'(w_k);
      if (en_i && !w_found && req_i[w_sel]) begin
        w_gnt[w_sel] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign w_idx     = IDX_W'(onehot_to_idx(MAX_REQ'(w_gnt)));
  assign gnt_o     = w_gnt;
  assign gnt_idx_o = w_idx;

  // Pointer moves one past the winner, wrapping explicitly at the last index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (adv_i && (|w_gnt)) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port byte-masked BRAM (1-cycle registered read) between
// NUM_REQ requesters. The BRAM is driven combinationally in the grant cycle;
// read data returns one cycle later and is held until the issuer accepts it.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/ready_o    : per-requester request handshake
//   req_wr/addr/data/mask_i: packed per-requester request fields
//   rsp_valid_o/ready_i    : per-requester read-response handshake
//   rsp_data_o             : shared read-data bus (0 when idle)
//   bram_*_o               : BRAM command port; bram_data_i is its read data
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BRAM_DEPTH = 128,
  parameter string       ARB_MODE   = ARB_RR,
  localparam int unsigned ADDR_WIDTH = addr_width(BRAM_DEPTH),
  localparam int unsigned MASK_W     = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ*MASK_W-1:0]     req_mask_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [DATA_WIDTH-1:0]         bram_data_o,
  output logic [ADDR_WIDTH-1:0]         bram_addr_o,
  output logic [MASK_W-1:0]             bram_mask_o,
  output logic                          bram_wr_en_o,
  output logic                          bram_cmd_en_o,
  input  logic [DATA_WIDTH-1:0]         bram_data_i
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic                  r_pending;
  logic [IDX_W-1:0]      r_rsp_id;
  logic                  w_stall;
  logic                  w_enable;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_cmd_en;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [MASK_W-1:0]     w_mask;

  // A held response freezes the BRAM output register, so no new command may issue.
  assign w_stall  = r_pending & ~rsp_ready_i[r_rsp_id];
  assign w_enable = rst_ni & ~w_stall;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .en_i      (w_enable),
    .adv_i     (1'b1),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Route the winner's fields to the BRAM; all zero without a grant.
  always_comb begin
    w_cmd_en = |w_gnt;
    w_wr_en  = |(w_gnt & req_wr_i);
    w_addr   = '0;
    w_data   = '0;
    w_mask   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        w_mask = req_mask_i[k*MASK_W +: MASK_W];
      end
    end
  end

  assign req_ready_o   = w_gnt;
  assign bram_cmd_en_o = w_cmd_en;
  assign bram_wr_en_o  = w_wr_en;
  assign bram_addr_o   = w_addr;
  assign bram_data_o   = w_data;
  assign bram_mask_o   = w_mask;

  assign rsp_valid_o = r_pending ? (NUM_REQ'(1) << r_rsp_id) : '0;
  assign rsp_data_o  = r_pending ? bram_data_i : '0;

  // Any grant replaces the pending state (a write clears it); otherwise a handshake retires it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= 1'b0;
      r_rsp_id  <= '0;
    end else if (w_cmd_en) begin
      r_pending <= ~w_wr_en;
      r_rsp_id  <= w_gnt_idx;
    end else if (r_pending && rsp_ready_i[r_rsp_id]) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: a BRAM behavioural model, a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_bram_port_arbiter;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int MW = DW / 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*MW-1:0] req_mask;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [DW-1:0]   bram_wdata;
  logic [AW-1:0]   bram_addr;
  logic [MW-1:0]   bram_mask;
  logic            bram_wr_en;
  logic            bram_cmd_en;
  logic [DW-1:0]   bram_rdata;

  int checks;
  int errors;

  bram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .BRAM_DEPTH(128), .ARB_MODE("RR")) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .bram_data_o(bram_wdata), .bram_addr_o(bram_addr), .bram_mask_o(bram_mask),
    .bram_wr_en_o(bram_wr_en), .bram_cmd_en_o(bram_cmd_en), .bram_data_i(bram_rdata)
  );

  // Three-requester instances for fixed-priority vs round-robin ordering.
  logic [2:0]  t3_valid;
  logic [2:0]  fx_ready, fx_rsp_valid, rr_ready, rr_rsp_valid;
  logic [31:0] fx_rsp_data, fx_bdata, rr_rsp_data, rr_bdata;
  logic [6:0]  fx_baddr, rr_baddr;
  logic [3:0]  fx_bmask, rr_bmask;
  logic        fx_bwr, fx_bcmd, rr_bwr, rr_bcmd;

  bram_port_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .BRAM_DEPTH(128), .ARB_MODE("FIXED")) dut_fx (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(t3_valid), .req_ready_o(fx_ready), .req_wr_i(3'b000),
    .req_addr_i(21'd0), .req_data_i(96'd0), .req_mask_i(12'd0),
    .rsp_valid_o(fx_rsp_valid), .rsp_ready_i(3'b111), .rsp_data_o(fx_rsp_data),
    .bram_data_o(fx_bdata), .bram_addr_o(fx_baddr), .bram_mask_o(fx_bmask),
    .bram_wr_en_o(fx_bwr), .bram_cmd_en_o(fx_bcmd), .bram_data_i(32'd0)
  );

  bram_port_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .BRAM_DEPTH(128), .ARB_MODE("RR")) dut_rr3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(t3_valid), .req_ready_o(rr_ready), .req_wr_i(3'b000),
    .req_addr_i(21'd0), .req_data_i(96'd0), .req_mask_i(12'd0),
    .rsp_valid_o(rr_rsp_valid), .rsp_ready_i(3'b111), .rsp_data_o(rr_rsp_data),
    .bram_data_o(rr_bdata), .bram_addr_o(rr_baddr), .bram_mask_o(rr_bmask),
    .bram_wr_en_o(rr_bwr), .bram_cmd_en_o(rr_bcmd), .bram_data_i(32'd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // BRAM: byte-masked write, registered read.
  logic [DW-1:0] env_mem [128];
  always @(posedge clk) begin
    if (bram_cmd_en) begin
      if (bram_wr_en) begin
        for (int b = 0; b < MW; b++)
          if (bram_mask[b]) env_mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
      end else begin
        bram_rdata <= env_mem[bram_addr];
      end
    end
  end

  // Reference model: one transaction at a time, responses as a single pending slot.
  logic [DW-1:0] m_mem [128];
  bit            m_pending;
  int            m_rsp_id;
  int            m_ptr;
  logic [DW-1:0] m_rsp_data;
  bit            e_gv;
  int            e_w;
  int            cand;
  bit            m_stall;
  logic [N-1:0]  e_ready, e_rsp_valid;
  logic [DW-1:0] e_rsp_data, e_data;
  logic [AW-1:0] e_addr;
  logic [MW-1:0] e_mask;
  logic          e_cmd, e_wr;

  always @(negedge clk) begin
    e_gv = 1'b0; e_w = 0;
    e_ready = '0; e_rsp_valid = '0; e_rsp_data = '0;
    e_cmd = 1'b0; e_wr = 1'b0; e_addr = '0; e_data = '0; e_mask = '0;
    if (!rst_n) begin
      m_pending = 1'b0; m_rsp_id = 0; m_ptr = 0;
    end else begin
      m_stall = m_pending && !rsp_ready[m_rsp_id];
      if (!m_stall) begin
        for (int i = 0; i < N; i++) begin
          cand = (m_ptr + i) % N;
          if (!e_gv && req_valid[cand]) begin e_gv = 1'b1; e_w = cand; end
        end
      end
      if (e_gv) begin
        e_ready[e_w] = 1'b1;
        e_cmd  = 1'b1;
        e_wr   = req_wr[e_w];
        e_addr = req_addr[e_w*AW +: AW];
        e_data = req_data[e_w*DW +: DW];
        e_mask = req_mask[e_w*MW +: MW];
      end
      if (m_pending) begin
        e_rsp_valid[m_rsp_id] = 1'b1;
        e_rsp_data = m_rsp_data;
      end
    end
    chk("m_req_ready", req_ready, e_ready);
    chk("m_rsp_valid", rsp_valid, e_rsp_valid);
    chk("m_rsp_data", rsp_data, e_rsp_data);
    chk("m_cmd_en", bram_cmd_en, e_cmd);
    chk("m_wr_en", bram_wr_en, e_wr);
    chk("m_addr", bram_addr, e_addr);
    chk("m_wdata", bram_wdata, e_data);
    chk("m_mask", bram_mask, e_mask);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (e_gv) begin
        if (e_wr) begin
          for (int b = 0; b < MW; b++)
            if (e_mask[b]) m_mem[e_addr][8*b +: 8] = e_data[8*b +: 8];
          m_pending = 1'b0;
        end else begin
          m_pending  = 1'b1;
          m_rsp_id   = e_w;
          m_rsp_data = m_mem[e_addr];
        end
        m_ptr = (e_w + 1) % N;
      end else if (m_pending && rsp_ready[m_rsp_id]) begin
        m_pending = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_wr[k]            = wr;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
    req_mask[k*MW +: MW] = m;
  endtask

  logic [2:0] rr3_exp [3];

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 128; i++) begin env_mem[i] = '0; m_mem[i] = '0; end
    bram_rdata = '0;
    rst_n = 1'b0;
    req_valid = 2'b11; req_wr = '0; req_addr = '0; req_data = '0; req_mask = '0;
    rsp_ready = 2'b11;
    t3_valid = 3'b000;
    rr3_exp[0] = 3'b100; rr3_exp[1] = 3'b001; rr3_exp[2] = 3'b010;

    // Held in reset with requests pending: nothing granted.
    repeat (2) step();
    #2;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_cmd", bram_cmd_en, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_addr", bram_addr, 7'd0);
    step();
    rst_n = 1'b1; req_valid = 2'b00;
    step();

    // Single write then read of address 5.
    set_req(0, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF); req_valid = 2'b01;
    #2;
    chk("wr_ready", req_ready, 2'b01);
    chk("wr_cmd", bram_cmd_en, 1'b1);
    chk("wr_we", bram_wr_en, 1'b1);
    chk("wr_addr", bram_addr, 7'd5);
    step(); req_valid = 2'b00;
    #2;
    chk("wr_cmd_pulse", bram_cmd_en, 1'b0);
    chk("wr_no_rsp", rsp_valid, 2'b00);
    step();
    set_req(0, 1'b0, 7'd5, 32'h0, 4'h0); req_valid = 2'b01;
    #2;
    chk("rd_cmd", bram_cmd_en, 1'b1);
    chk("rd_we", bram_wr_en, 1'b0);
    step(); req_valid = 2'b00;
    #2;
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_data", rsp_data, 32'hDEADBEEF);
    step();
    #2;
    chk("rd_rsp_done", rsp_valid, 2'b00);
    chk("rd_rsp_zero", rsp_data, 32'h0);

    // Reset in the cycle after a read accept (pointer was 1 before reset).
    step();
    req_valid = 2'b01;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_cmd", bram_cmd_en, 1'b0);
    chk("midrst_ready", req_ready, 2'b00);
    step();
    rst_n = 1'b1;

    // Both read continuously: grants alternate starting at 0 (pointer reset).
    set_req(1, 1'b0, 7'd6, 32'h0, 4'h0);
    req_valid = 2'b11;
    #2;
    chk("rr_grant0", req_ready, 2'b01);
    for (int i = 1; i < 6; i++) begin
      step();
      #2;
      chk("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_rsp_onehot", rsp_valid, (i % 2 == 1) ? 2'b01 : 2'b10);
      chk("rr_rsp_data", rsp_data, (i % 2 == 1) ? 32'hDEADBEEF : 32'h0);
    end
    step(); req_valid = 2'b00;
    step();

    // Response backpressure on requester 1 blocks requester 0.
    set_req(1, 1'b0, 7'd5, 32'h0, 4'h0); req_valid = 2'b10;
    #2;
    chk("bp_accept", req_ready, 2'b10);
    step();
    set_req(0, 1'b0, 7'd6, 32'h0, 4'h0); req_valid = 2'b01; rsp_ready = 2'b01;
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("bp_ready", req_ready, 2'b00);
      chk("bp_cmd", bram_cmd_en, 1'b0);
      chk("bp_rsp_valid", rsp_valid, 2'b10);
      chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      step();
    end
    rsp_ready = 2'b11;
    #2;
    chk("bp_release_grant", req_ready, 2'b01);
    chk("bp_release_rsp", rsp_valid, 2'b10);
    step(); req_valid = 2'b00;
    step();

    // Byte mask merge, including an all-zero-mask write.
    set_req(1, 1'b1, 7'd3, 32'hFFFFFFFF, 4'hF); req_valid = 2'b10;
    step();
    set_req(1, 1'b1, 7'd3, 32'h00000012, 4'h1);
    step();
    set_req(1, 1'b1, 7'd3, 32'h00000000, 4'h0);
    #2;
    chk("zmask_cmd", bram_cmd_en, 1'b1);
    chk("zmask_mask", bram_mask, 4'h0);
    step();
    set_req(1, 1'b0, 7'd3, 32'h0, 4'h0);
    step(); req_valid = 2'b00;
    #2;
    chk("mask_rsp_valid", rsp_valid, 2'b10);
    chk("mask_rsp_data", rsp_data, 32'hFFFFFF12);
    step();

    // A write accepted alongside a response handshake clears pending.
    set_req(0, 1'b0, 7'd3, 32'h0, 4'h0); req_valid = 2'b01;
    step();
    set_req(0, 1'b1, 7'd7, 32'h000000AA, 4'hF);
    #2;
    chk("wrhs_grant", req_ready, 2'b01);
    chk("wrhs_rsp_data", rsp_data, 32'hFFFFFF12);
    step(); req_valid = 2'b00;
    #2;
    chk("wrhs_cleared", rsp_valid, 2'b00);
    step();

    // Three requesters: fixed always picks 0; RR from pointer 2 gives 2,0,1.
    t3_valid = 3'b010;
    #2;
    chk("fx_single", fx_ready, 3'b010);
    chk("rr3_single", rr_ready, 3'b010);
    step();
    t3_valid = 3'b111;
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("fx_grant", fx_ready, 3'b001);
      chk("rr3_grant", rr_ready, rr3_exp[j]);
      step();
    end
    t3_valid = 3'b000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port byte-masked BRAM (1-cycle registered read) between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Arbitration is round-robin or fixed-priority.
- Sits between cache/engine-side clients and the BRAM instance; the BRAM is driven directly from the grant cycle.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- DATA_WIDTH, 32, BRAM word width; multiple of 8.
- BRAM_DEPTH, 128, BRAM words; ADDR_WIDTH = $clog2(BRAM_DEPTH) (localparam).
- ARB_MODE, "RR", "RR" = round-robin, "FIXED" = lowest index wins.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  async active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_wr_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_mask_i  in  NUM_REQ*DATA_WIDTH/8  packed byte enables.
- rsp_valid_o  out  NUM_REQ  one-hot read-data valid to the issuing requester.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_data_o  out  DATA_WIDTH  read data; shared bus.
- bram_data_o  out  DATA_WIDTH  write data to BRAM.
- bram_addr_o  out  ADDR_WIDTH  BRAM address.
- bram_mask_o  out  DATA_WIDTH/8  BRAM byte mask.
- bram_wr_en_o  out  1  BRAM write enable.
- bram_cmd_en_o  out  1  BRAM command enable.
- bram_data_i  in  DATA_WIDTH  BRAM registered read data.

Behaviour:
- Reset (rst_ni low, async):
  - rsp pending flag = 0; rsp_id = 0; RR pointer = 0.
  - req_ready_o = 0, rsp_valid_o = 0, bram_cmd_en_o = 0, bram_wr_en_o = 0.
  - bram_addr_o, bram_data_o, bram_mask_o = 0.
  - A response in flight at reset is dropped and never presented.
- Stall:
  - stall = pending & ~rsp_ready_i[rsp_id].
  - While stall, all req_ready_o = 0 and bram_cmd_en_o = 0. This protects the BRAM output register, which only changes on a new command.
- Grant (combinational, same cycle):
  - If !stall and any req_valid_i, select winner w.
  - RR: first valid index scanning from pointer upward, wrapping modulo NUM_REQ.
  - FIXED: lowest valid index.
  - req_ready_o[w] = 1. bram_cmd_en_o = 1, bram_wr_en_o = req_wr_i[w]. bram_addr_o, bram_data_o, bram_mask_o take w's slices.
  - With no grant, the bram_* data/addr/mask outputs are 0.
- Handshake:
  - Requests are accepted only when valid & ready.
  - Requesters must hold fields stable until accepted.
  - Ready may depend on valid (combinational).
- RR pointer: on each accepted request, pointer <= (w+1) mod NUM_REQ, with explicit wrap at NUM_REQ-1. Unchanged when no grant. Ignored in FIXED mode.
- Read latency:
  - Read accepted in cycle N: in cycle N+1, pending=1, rsp_id=w, rsp_valid_o[w]=1, rsp_data_o=bram_data_i.
  - Response is held (BRAM not re-commanded) until rsp_ready_i[rsp_id].
- Response pipelining:
  - In a cycle with rsp_valid_o & rsp_ready_i, a new grant is allowed, giving back-to-back reads at 1/cycle.
  - pending <= (new read accepted this cycle).
- Writes:
  - Accepted writes produce no response; they are complete at the accept edge.
  - A write accepted in the same cycle as a response handshake clears pending.
  - A write with all-zero mask is still issued (no-op in the BRAM).
- rsp_data_o = 0 when !pending.
- A requester's rsp_ready_i is ignored unless its rsp_valid_o is high.
- NUM_REQ=1: grant = req_valid_i & !stall; pointer stays 0.

Decomposition:
- Package bram_arb_pkg:
  - ARB_MODE string constants.
  - Helper function for one-hot-to-index.
  - Packed-slice width macros (ADDR_WIDTH derivation).
- Sub-module rr_arbiter (NUM_REQ, ARB_MODE):
  - Inputs: req vector, enable, advance.
  - Outputs: one-hot grant, grant index.
  - Owns the pointer register and the async reset.

Test Plan:
1. Reset mid-read: assert rst_ni=0 in the cycle after a read accept -> rsp_valid_o=0 and bram_cmd_en_o=0 immediately; after release, pointer=0.
2. Single write/read: req0 writes addr 5, data 0xDEADBEEF, mask 0xF, then reads addr 5 -> bram_cmd_en_o/bram_wr_en_o pulse one cycle; rsp_valid_o=2'b01 and rsp_data_o=0xDEADBEEF exactly one cycle after the read accept.
3. Round-robin fairness: both requesters read continuously with rsp_ready_i=2'b11 -> grants alternate 0,1,0,1 with one accept per cycle; responses are one-hot to the matching requester.
4. Response backpressure: req1 read, hold rsp_ready_i[1]=0 for 3 cycles with req0 valid -> req_ready_o=0 and bram_cmd_en_o=0 for those cycles, rsp_data_o stable; req0 is granted in the same cycle rsp_ready_i[1] rises.
5. Byte mask: write 0xFFFFFFFF to addr 3, then write 0x00000012 with mask 0x1, then read -> rsp_data_o=0xFFFFFF12.
6. FIXED mode wrap: ARB_MODE="FIXED", NUM_REQ=3, all valid -> req0 always granted. Same stimulus in "RR" from pointer=2 -> grant order 2,0,1.
